// File: rtl/apb_arbiter.sv
// Two-master (M0 Sampler, M1 Computer) to one-slave (Memory) APB arbiter that runs
// its own SETUP/ACCESS phases. Define RR_ARB_EN for round-robin ties; otherwise M0 wins.
module apb_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              pclk_i,
    input  logic              preset_i,

    input  logic              m0_psel_i,
    input  logic              m0_penable_i,
    input  logic [ADDR_W-1:0] m0_paddr_i,
    input  logic [DATA_W-1:0] m0_pwdata_i,
    input  logic              m0_pwrite_i,
    output logic [DATA_W-1:0] m0_prdata_o,
    output logic              m0_pready_o,
    output logic              m0_pslverr_o,

    input  logic              m1_psel_i,
    input  logic              m1_penable_i,
    input  logic [ADDR_W-1:0] m1_paddr_i,
    input  logic [DATA_W-1:0] m1_pwdata_i,
    input  logic              m1_pwrite_i,
    output logic [DATA_W-1:0] m1_prdata_o,
    output logic              m1_pready_o,
    output logic              m1_pslverr_o,

    output logic              s_psel_o,
    output logic              s_penable_o,
    output logic [ADDR_W-1:0] s_paddr_o,
    output logic [DATA_W-1:0] s_pwdata_o,
    output logic              s_pwrite_o,
    input  logic [DATA_W-1:0] s_prdata_i,
    input  logic              s_pready_i,
    input  logic              s_pslverr_i,

    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] req;
    logic [1:0] winner;
    logic       in_access;
    logic       done;
    logic       m0_live;
    logic       m1_live;

    assign req       = {m1_psel_i, m0_psel_i};
    assign in_access = (state == ACCESS);
    assign done      = in_access & s_pready_i;

`ifdef RR_ARB_EN
    logic rr_ptr;  // 0 prefers M0, 1 prefers M1 on a tie

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        winner = req;
        if (req == 2'b11)
            winner = rr_ptr ? 2'b10 : 2'b01;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i)
            rr_ptr <= 1'b0;
        else if (done)
            rr_ptr <= grant_o[0];
    end
`else
    always_comb begin
        winner = 2'b00;
        if (req[0])
            winner = 2'b01;
        else if (req[1])
            winner = 2'b10;
    end
`endif

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            state       <= IDLE;
            grant_o     <= 2'b00;
            s_psel_o    <= 1'b0;
            s_penable_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_o  <= winner;
                        s_psel_o <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    s_penable_o <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (s_pready_i) begin
                        grant_o     <= 2'b00;
                        s_psel_o    <= 1'b0;
                        s_penable_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_paddr_o  = '0;
        s_pwdata_o = '0;
        s_pwrite_o = 1'b0;
        if (state != IDLE) begin
            if (grant_o[1]) begin
                s_paddr_o  = m1_paddr_i;
                s_pwdata_o = m1_pwdata_i;
                s_pwrite_o = m1_pwrite_i;
            end else if (grant_o[0]) begin
                s_paddr_o  = m0_paddr_i;
                s_pwdata_o = m0_pwdata_i;
                s_pwrite_o = m0_pwrite_i;
            end
        end
    end

    // A granted master that abandoned its ACCESS phase gets no response; the slave
    // transfer still runs to completion.
    assign m0_live = grant_o[0] & in_access & m0_psel_i & m0_penable_i;
    assign m1_live = grant_o[1] & in_access & m1_psel_i & m1_penable_i;

    assign m0_pready_o  = m0_live & s_pready_i;
    assign m0_pslverr_o = m0_live & s_pslverr_i;
    assign m0_prdata_o  = m0_live ? s_prdata_i : '0;

    assign m1_pready_o  = m1_live & s_pready_i;
    assign m1_pslverr_o = m1_live & s_pslverr_i;
    assign m1_prdata_o  = m1_live ? s_prdata_i : '0;

endmodule
